// File: rtl/vec_alu_seq_if.sv
// Command / lane / response bundle between a vec_alu sequencer and its
// environment. The slave side is the sequencer; the master side issues
// commands, returns lane done pulses and consumes responses.
interface vec_alu_seq_if #(
    parameter int MAX_LANES_LOG2 = 2
);
    localparam int LANES = 1 << MAX_LANES_LOG2;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [5:0]       cmd_opcode;
    logic [2:0]       cmd_vsew;
    logic [2:0]       cmd_op_type;
    logic [1:0]       cmd_nb_lanes;

    logic             alu_run;
    logic [5:0]       alu_opcode;
    logic [2:0]       alu_vsew;
    logic [2:0]       alu_op_type;
    logic [1:0]       alu_nb_lanes;
    logic [LANES-1:0] lane_done;

    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_err;
    logic [15:0]      resp_cycles;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_vsew, cmd_op_type, cmd_nb_lanes,
        input  lane_done, resp_ready,
        output cmd_ready, alu_run, alu_opcode, alu_vsew, alu_op_type, alu_nb_lanes,
        output resp_valid, resp_err, resp_cycles
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_vsew, cmd_op_type, cmd_nb_lanes,
        output lane_done, resp_ready,
        input  cmd_ready, alu_run, alu_opcode, alu_vsew, alu_op_type, alu_nb_lanes,
        input  resp_valid, resp_err, resp_cycles
    );
endinterface

// File: rtl/vec_alu_seq.sv
// Sequencer for a group of vec_alu lanes: accepts one command, checks it,
// strobes alu_run until every active lane reports done (or a timeout),
// inserts one idle DRAIN cycle, then holds a response until it is taken.
module vec_alu_seq #(
    parameter int          MAX_LANES_LOG2 = 2,
    parameter logic [15:0] TIMEOUT        = 16'd1023
) (
    input  logic         clk,
    input  logic         resetn,
    vec_alu_seq_if.slave bus
);
    localparam int LANES = 1 << MAX_LANES_LOG2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

    state_t           state_q;
    logic             cmd_ready_q;
    logic             alu_run_q;
    logic [5:0]       alu_opcode_q;
    logic [2:0]       alu_vsew_q;
    logic [2:0]       alu_op_type_q;
    logic [1:0]       alu_nb_lanes_q;
    logic             resp_valid_q;
    logic [1:0]       resp_err_q;
    logic [15:0]      resp_cycles_q;
    logic [LANES-1:0] done_seen_q;
    logic [15:0]      cnt_q;

    logic             cmd_fire;
    logic             cmd_legal;
    logic [LANES-1:0] active_mask;
    logic [LANES-1:0] done_seen_d;
    logic             all_done_q;
    logic             all_done_now;
    logic [15:0]      cnt_d;
    logic             timeout_hit;

    function automatic logic cmd_is_legal(
        input logic [5:0] op,
        input logic [2:0] vsew,
        input logic [2:0] op_type,
        input logic [1:0] nb_lanes
    );
        logic op_ok;
        logic type_ok;
        logic lanes_ok;
        op_ok    = (op == 6'b000000) || (op == 6'b001001) ||
                   (op == 6'b001010) || (op == 6'b001011);
        type_ok  = (op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100);
        lanes_ok = ({30'd0, nb_lanes} <= 32'(MAX_LANES_LOG2));
        return op_ok && (vsew <= 3'd3) && type_ok && lanes_ok;
    endfunction

    assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
    assign cmd_legal = cmd_is_legal(bus.cmd_opcode, bus.cmd_vsew,
                                    bus.cmd_op_type, bus.cmd_nb_lanes);

    // Lanes 0 .. 2^nb_lanes-1 are active for the latched command.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign active_mask[gi] = (32'(gi) < (32'd1 << alu_nb_lanes_q));
    end

    // Done pulses from inactive lanes never reach the sticky bits.
    assign done_seen_d  = done_seen_q | (bus.lane_done & active_mask);
    // Normal exit looks at the registered bits, giving one cycle after the
    // last pulse; the timeout arbitration also counts this cycle's pulses
    // so a completion coinciding with the timeout still reports success.
    assign all_done_q   = &(done_seen_q | ~active_mask);
    assign all_done_now = &(done_seen_d | ~active_mask);
    assign cnt_d        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign timeout_hit  = (cnt_d >= TIMEOUT);

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b0;
            alu_run_q      <= 1'b0;
            alu_opcode_q   <= '0;
            alu_vsew_q     <= '0;
            alu_op_type_q  <= '0;
            alu_nb_lanes_q <= '0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 2'b00;
            resp_cycles_q  <= '0;
            done_seen_q    <= '0;
            cnt_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        alu_opcode_q   <= bus.cmd_opcode;
                        alu_vsew_q     <= bus.cmd_vsew;
                        alu_op_type_q  <= bus.cmd_op_type;
                        alu_nb_lanes_q <= bus.cmd_nb_lanes;
                        done_seen_q    <= '0;
                        cnt_q          <= '0;
                        cmd_ready_q    <= 1'b0;
                        if (cmd_legal) begin
                            state_q   <= RUN;
                            alu_run_q <= 1'b1;
                        end else begin
                            state_q       <= RESP;
                            resp_valid_q  <= 1'b1;
                            resp_err_q    <= 2'b01;
                            resp_cycles_q <= '0;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q       <= cnt_d;
                    done_seen_q <= done_seen_d;
                    if (all_done_q || timeout_hit) begin
                        state_q       <= DRAIN;
                        alu_run_q     <= 1'b0;
                        resp_cycles_q <= cnt_d;
                        resp_err_q    <= (all_done_q || all_done_now) ? 2'b00 : 2'b10;
                    end
                end
                DRAIN: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.alu_run      = alu_run_q;
    assign bus.alu_opcode   = alu_opcode_q;
    assign bus.alu_vsew     = alu_vsew_q;
    assign bus.alu_op_type  = alu_op_type_q;
    assign bus.alu_nb_lanes = alu_nb_lanes_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_cycles  = resp_cycles_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed bench for vec_alu_seq: legal, illegal, partial-lane, timeout,
// timeout/completion tie, response back-pressure and mid-run reset.
module tb_vec_alu_seq;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    vec_alu_seq_if #(.MAX_LANES_LOG2(2)) bus ();

    vec_alu_seq #(
        .MAX_LANES_LOG2(2),
        .TIMEOUT       (16'd16)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, pulse lane_done on the given RUN cycles (0 = never),
    // then check run length, drain gap and response, holding resp_ready low
    // for 'hold' extra cycles.
    task automatic do_cmd(input string tag, input logic [5:0] op, input logic [2:0] vsew,
                          input logic [2:0] ot, input logic [1:0] nb,
                          input int p0, input int p1, input int p2, input int p3,
                          input int exp_run, input logic [1:0] exp_err,
                          input logic [15:0] exp_cyc, input int hold);
        int n;
        chk({tag, ".ready"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_opcode   = op;
        bus.cmd_vsew     = vsew;
        bus.cmd_op_type  = ot;
        bus.cmd_nb_lanes = nb;
        @(negedge clk);
        bus.cmd_valid    = 1'b0;
        bus.cmd_opcode   = 6'h3F;
        bus.cmd_vsew     = 3'h7;
        bus.cmd_op_type  = 3'h7;
        bus.cmd_nb_lanes = 2'h3;
        n = 0;
        while (bus.alu_run && n < 100) begin
            n++;
            bus.lane_done = {(p3 == n), (p2 == n), (p1 == n), (p0 == n)};
            @(negedge clk);
            bus.lane_done = '0;
        end
        chk({tag, ".run_len"}, n, exp_run);
        if (exp_run > 0) begin
            chk({tag, ".drain"}, bus.resp_valid, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i <= hold; i++) begin
            chk({tag, ".valid"}, bus.resp_valid, 1'b1);
            chk({tag, ".err"}, bus.resp_err, exp_err);
            chk({tag, ".cycles"}, bus.resp_cycles, exp_cyc);
            chk({tag, ".busy"}, bus.cmd_ready, 1'b0);
            chk({tag, ".alu_op"}, {bus.alu_opcode, bus.alu_vsew, bus.alu_op_type, bus.alu_nb_lanes},
                {op, vsew, ot, nb});
            if (i < hold) @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk({tag, ".released"}, bus.resp_valid, 1'b0);
        $display("cmd %s: run=%0d err=%0b cycles=%0d", tag, n, exp_err, exp_cyc);
    endtask

    initial begin
        int seen;
        n_cmp            = 0;
        n_err            = 0;
        resetn           = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_opcode   = '0;
        bus.cmd_vsew     = '0;
        bus.cmd_op_type  = '0;
        bus.cmd_nb_lanes = '0;
        bus.lane_done    = '0;
        bus.resp_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst.alu_run", bus.alu_run, 1'b0);
        chk("rst.alu_fields", {bus.alu_opcode, bus.alu_vsew, bus.alu_op_type, bus.alu_nb_lanes}, 0);
        chk("rst.resp_valid", bus.resp_valid, 1'b0);
        chk("rst.resp", {bus.resp_err, bus.resp_cycles}, 0);
        resetn = 1'b1;
        @(negedge clk);

        do_cmd("vadd",     6'b000000, 3'd2, 3'b001, 2'd2,  5,  5,  6,  7,  8, 2'b00, 16'd8, 0);
        do_cmd("illegal",  6'b000001, 3'd4, 3'b001, 2'd0,  0,  0,  0,  0,  0, 2'b01, 16'd0, 0);
        do_cmd("nb1_spur", 6'b001001, 3'd0, 3'b010, 2'd1,  3,  6,  2,  4,  7, 2'b00, 16'd7, 0);
        do_cmd("nb0",      6'b001011, 3'd1, 3'b100, 2'd0,  5,  2,  0,  0,  6, 2'b00, 16'd6, 0);
        do_cmd("timeout",  6'b001010, 3'd1, 3'b100, 2'd2,  0,  0,  0,  0, 16, 2'b10, 16'd16, 0);
        do_cmd("to_tie",   6'b001011, 3'd3, 3'b001, 2'd2,  2,  2,  2, 16, 16, 2'b00, 16'd16, 0);
        do_cmd("hold",     6'b000000, 3'd0, 3'b001, 2'd0,  4,  0,  0,  0,  5, 2'b00, 16'd5, 10);
        do_cmd("bad_nb",   6'b000000, 3'd0, 3'b001, 2'd3,  0,  0,  0,  0,  0, 2'b01, 16'd0, 0);
        do_cmd("bad_type", 6'b001001, 3'd1, 3'b011, 2'd0,  0,  0,  0,  0,  0, 2'b01, 16'd0, 0);

        // Reset during RUN cycle 3 discards the command.
        chk("mid_rst.ready", bus.cmd_ready, 1'b1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_opcode   = 6'b001010;
        bus.cmd_vsew     = 3'd2;
        bus.cmd_op_type  = 3'b010;
        bus.cmd_nb_lanes = 2'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst.running", bus.alu_run, 1'b1);
        resetn = 1'b0;
        #1;
        chk("mid_rst.alu_run", bus.alu_run, 1'b0);
        chk("mid_rst.cmd_ready", bus.cmd_ready, 1'b0);
        chk("mid_rst.alu_fields", {bus.alu_opcode, bus.alu_vsew, bus.alu_op_type, bus.alu_nb_lanes}, 0);
        chk("mid_rst.resp", {bus.resp_valid, bus.resp_err, bus.resp_cycles}, 0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.alu_run) seen++;
        end
        chk("mid_rst.no_resp", seen, 0);
        $display("cmd mid_rst: command discarded by reset");
        do_cmd("post_rst", 6'b001001, 3'd3, 3'b100, 2'd1, 1, 3, 0, 0, 4, 2'b00, 16'd4, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vec_alu_seq.md
VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 The block SHALL have parameter MAX_LANES_LOG2, default 2, meaning log2 of the number of physical vec_alu lanes attached (1..3).
REQ-002 The block SHALL have parameter TIMEOUT, default 16'd1023, meaning the maximum number of RUN cycles before a forced abort.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-007 The block SHALL have ports cmd_opcode (input, 6 bits), cmd_vsew (input, 3 bits), cmd_op_type (input, 3 bits) and cmd_nb_lanes (input, 2 bits): the command fields.
REQ-008 The block SHALL have port alu_run, output, 1 bit: the run strobe to all lanes.
REQ-009 The block SHALL have ports alu_opcode (6 bits), alu_vsew (3 bits), alu_op_type (3 bits) and alu_nb_lanes (2 bits), all outputs: the latched command fields driven to the lanes.
REQ-010 The block SHALL have port lane_done, input, 2^MAX_LANES_LOG2 bits: the per-lane one-cycle done pulses.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a completion response is presented.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 The block SHALL have port resp_err, output, 2 bits: response status, 00 ok, 01 illegal, 10 timeout.
REQ-014 The block SHALL have port resp_cycles, output, 16 bits: the number of cycles alu_run was high for this command.

Function
REQ-015 The block SHALL implement exactly four states: IDLE, RUN, DRAIN and RESP.
REQ-016 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0; a command is accepted only when cmd_valid and cmd_ready are both 1.
REQ-017 On acceptance, the block SHALL register opcode, vsew, op_type and nb_lanes into the alu_* outputs; these SHALL hold stable until the next acceptance.
REQ-018 A command SHALL be legal only when all of the following hold: opcode is one of 000000, 001001, 001010 or 001011; vsew ≤ 3; op_type is 001, 010 or 100; cmd_nb_lanes ≤ MAX_LANES_LOG2.
REQ-019 A legal command SHALL move the block IDLE→RUN; an illegal command SHALL move it IDLE→RESP with resp_err=01, resp_cycles=0, and alu_run never asserted.
REQ-020 In RUN, alu_run SHALL be 1; the first RUN cycle is the cycle after acceptance.
REQ-021 Active lanes SHALL be lanes 0..(2^nb_lanes)-1; a sticky done_seen bit per active lane SHALL set on its lane_done pulse.
REQ-022 lane_done on inactive lanes SHALL be ignored.
REQ-023 done_seen SHALL clear on acceptance.
REQ-024 RUN SHALL exit to DRAIN in the cycle after all active done_seen bits (including same-cycle pulses) are set, with resp_err=00.
REQ-025 A cycle counter SHALL increment each RUN cycle, saturate at 16'hFFFF, and be copied to resp_cycles on RUN exit.
REQ-026 If the counter reaches TIMEOUT while RUN and not all done, the block SHALL go to DRAIN with resp_err=10.
REQ-027 When timeout and completion occur in the same cycle, completion SHALL win.
REQ-028 DRAIN SHALL last exactly one cycle with alu_run=0, so lanes clear their internal counters, then go to RESP.
REQ-029 In RESP, resp_valid SHALL be 1, and resp_err and resp_cycles SHALL be stable.
REQ-030 RESP→IDLE SHALL occur when resp_ready=1; with resp_ready held low, RESP SHALL persist indefinitely.
REQ-031 A new command SHALL not be accepted in the RESP→IDLE transition cycle; back-to-back throughput is one command per RUN+3 cycles.

Reset
REQ-032 While resetn=0, the block SHALL force state=IDLE, alu_run=0, alu_opcode=0, alu_vsew=0, alu_op_type=0, alu_nb_lanes=0, resp_valid=0, resp_err=00, resp_cycles=0, done_seen=0 and counter=0, asynchronously.
REQ-033 While resetn=0, cmd_ready SHALL be 0.
REQ-034 A reset asserted mid-RUN or mid-RESP SHALL discard the command with no response produced.

Verification
REQ-035 Legal vadd (opcode 000000, vsew=2, op_type=001, nb_lanes=2): lanes 0-3 pulse done on cycles 5, 5, 6 and 7 of RUN -> alu_run high for 8 cycles, DRAIN one cycle, then resp_valid with err=00 and cycles=8.
REQ-036 Illegal command (opcode 000001, vsew=4) -> resp_valid in cycle 2 with err=01 and cycles=0, and alu_run never high.
REQ-037 With nb_lanes=1 and done pulsed only on lanes 0 and 1 (lanes 2-3 silent) -> completes with err=00; a spurious pulse on lane 3 has no effect.
REQ-038 With no lane_done pulses and TIMEOUT=16 -> RUN for 16 cycles, then err=10 and cycles=16; a completion pulse coinciding with the timeout cycle -> err=00.
REQ-039 With resp_ready held low for 10 cycles -> resp_valid and its fields stay stable, and cmd_ready stays 0 throughout.
REQ-040 resetn pulsed low during RUN cycle 3 -> all outputs at reset values immediately, no resp_valid afterwards, and the next command runs normally.
